// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode/hazard constants: Tuse/Tnew encodings and forward-select codes.
package hazard_scoreboard_pkg;

    localparam int TW_DEF = 2;
    localparam int SW_DEF = 2;

    localparam logic [TW_DEF-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TW_DEF-1:0] TNEW_DM   = 2'd2;
    localparam logic [TW_DEF-1:0] TNEW_PC   = 2'd0;
    localparam logic [TW_DEF-1:0] TUSE_NONE = 2'd3;

    localparam logic [SW_DEF-1:0] FWD_RF = 2'd0;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-source priority search: youngest (lowest-index) writer slot whose
// destination equals the source address.
module hazard_scoreboard_match #(
    parameter int DEPTH    = 3,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int ZERO_REG = 1,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic                        en,
    input  logic [AW-1:0]               addr,
    input  logic [DEPTH-1:0]            slot_valid,
    input  logic [DEPTH-1:0][AW-1:0]    slot_wa,
    input  logic [DEPTH-1:0][TW-1:0]    slot_tnew,
    output logic                        hit,
    output logic [SW-1:0]               idx,
    output logic [TW-1:0]               tnew
);

    logic [DEPTH-1:0] match_s;

    // Per-slot writer/address match; wa==0 is never a writer when ZERO_REG is set.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = en && slot_valid[i] && (slot_wa[i] == addr) &&
                         ((ZERO_REG == 0) || (slot_wa[i] != '0));
        end
    end

    // Scan oldest to youngest so the youngest match overwrites and wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        tnew = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit  = match_s[i] ? 1'b1         : hit;
            idx  = match_s[i] ? SW'(i)       : idx;
            tnew = match_s[i] ? slot_tnew[i] : tnew;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: shift scoreboard of in-flight writers, decode stall
// and D-stage forward selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int ZERO_REG = 1,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [AW-1:0]    d_ra1,
    input  logic [AW-1:0]    d_ra2,
    input  logic [TW-1:0]    d_tuse_rs,
    input  logic             d_tuse_rs_en,
    input  logic [TW-1:0]    d_tuse_rt,
    input  logic             d_tuse_rt_en,
    input  logic [AW-1:0]    d_wa,
    input  logic [TW-1:0]    d_tnew,
    input  logic             d_md,
    input  logic             md_busy,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic [SW-1:0]    fwd_rs,
    output logic [SW-1:0]    fwd_rt,
    output logic [DEPTH-1:0] sb_valid
);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] wa_q, wa_d;
    logic [DEPTH-1:0][TW-1:0] tnew_q, tnew_d;

    logic          rs_hit_s, rt_hit_s;
    logic [SW-1:0] rs_idx_s, rt_idx_s;
    logic [TW-1:0] rs_tnew_s, rt_tnew_s;
    logic          stall_s;
    logic [SW-1:0] fwd_rs_s, fwd_rt_s;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? t : (t - TW'(1));
    endfunction

    hazard_scoreboard_match #(
        .DEPTH(DEPTH), .AW(AW), .TW(TW), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match_rs (
        .en        (d_valid && d_tuse_rs_en),
        .addr      (d_ra1),
        .slot_valid(valid_q),
        .slot_wa   (wa_q),
        .slot_tnew (tnew_q),
        .hit       (rs_hit_s),
        .idx       (rs_idx_s),
        .tnew      (rs_tnew_s)
    );

    hazard_scoreboard_match #(
        .DEPTH(DEPTH), .AW(AW), .TW(TW), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match_rt (
        .en        (d_valid && d_tuse_rt_en),
        .addr      (d_ra2),
        .slot_valid(valid_q),
        .slot_wa   (wa_q),
        .slot_tnew (tnew_q),
        .hit       (rt_hit_s),
        .idx       (rt_idx_s),
        .tnew      (rt_tnew_s)
    );

    // Stall and forward selects; a pending result that is not yet ready but
    // will be by its use stage neither stalls nor forwards here.
    always_comb begin
        stall_s = d_valid && ((rs_hit_s && (rs_tnew_s > d_tuse_rs)) ||
                              (rt_hit_s && (rt_tnew_s > d_tuse_rt)) ||
                              (d_md && md_busy));
        if (rs_hit_s && (rs_tnew_s == '0)) begin
            fwd_rs_s = rs_idx_s + SW'(1);
        end else begin
            fwd_rs_s = SW'(FWD_RF);
        end
        if (rt_hit_s && (rt_tnew_s == '0)) begin
            fwd_rt_s = rt_idx_s + SW'(1);
        end else begin
            fwd_rt_s = SW'(FWD_RF);
        end
    end

    // Next scoreboard state: flush beats hold beats shift.
    always_comb begin
        valid_d = valid_q;
        wa_d    = wa_q;
        tnew_d  = tnew_q;
        if (flush) begin
            valid_d = '0;
        end else if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                wa_d[i]    = wa_q[i-1];
                tnew_d[i]  = sat_dec(tnew_q[i-1]);
            end
            if (stall_s || !d_valid) begin
                valid_d[0] = 1'b0;
            end else begin
                valid_d[0] = 1'b1;
                wa_d[0]    = d_wa;
                tnew_d[0]  = d_tnew;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            wa_q    <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            wa_q    <= wa_d;
            tnew_q  <= tnew_d;
        end
    end

    assign stall    = stall_s;
    assign fwd_rs   = fwd_rs_s;
    assign fwd_rt   = fwd_rt_s;
    assign sb_valid = valid_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed decode vectors push their
// hand-computed outputs; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_ra1, d_ra2, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_tuse_rs_en, d_tuse_rt_en;
    logic       d_md, md_busy, hold, flush;
    logic       stall;
    logic [1:0] fwd_rs, fwd_rt;
    logic [2:0] sb_valid;

    typedef struct {
        logic       st;
        logic [1:0] fr;
        logic [1:0] ft;
        logic [2:0] sb;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_ra1       (d_ra1),
        .d_ra2       (d_ra2),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rs_en(d_tuse_rs_en),
        .d_tuse_rt   (d_tuse_rt),
        .d_tuse_rt_en(d_tuse_rt_en),
        .d_wa        (d_wa),
        .d_tnew      (d_tnew),
        .d_md        (d_md),
        .md_busy     (md_busy),
        .hold        (hold),
        .flush       (flush),
        .stall       (stall),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .sb_valid    (sb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {reset, d_md, md_busy, hold, flush}
    task automatic cyc(input logic dv, input logic [4:0] r1, input logic e1, input logic [1:0] u1,
                       input logic [4:0] r2, input logic e2, input logic [1:0] u2,
                       input logic [4:0] wa, input logic [1:0] tn, input logic [4:0] ctl,
                       input logic est, input logic [1:0] efr, input logic [1:0] eft,
                       input logic [2:0] esb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = ctl[4]; d_md = ctl[3]; md_busy = ctl[2]; hold = ctl[1]; flush = ctl[0];
        d_valid = dv; d_ra1 = r1; d_tuse_rs_en = e1; d_tuse_rs = u1;
        d_ra2 = r2; d_tuse_rt_en = e2; d_tuse_rt = u2; d_wa = wa; d_tnew = tn;
        e.st = est; e.fr = efr; e.ft = eft; e.sb = esb; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks += 4;
            if (stall !== mon_e.st) begin
                errors++;
                $display("FAIL %s stall: got %0b expected %0b", mon_e.nm, stall, mon_e.st);
            end
            if (fwd_rs !== mon_e.fr) begin
                errors++;
                $display("FAIL %s fwd_rs: got %0d expected %0d", mon_e.nm, fwd_rs, mon_e.fr);
            end
            if (fwd_rt !== mon_e.ft) begin
                errors++;
                $display("FAIL %s fwd_rt: got %0d expected %0d", mon_e.nm, fwd_rt, mon_e.ft);
            end
            if (sb_valid !== mon_e.sb) begin
                errors++;
                $display("FAIL %s sb_valid: got %03b expected %03b", mon_e.nm, sb_valid, mon_e.sb);
            end
        end
    end

    initial begin
        reset = 1'b1; d_valid = 1'b0; d_ra1 = '0; d_ra2 = '0; d_wa = '0;
        d_tuse_rs = '0; d_tuse_rt = '0; d_tnew = '0; d_tuse_rs_en = 1'b0; d_tuse_rt_en = 1'b0;
        d_md = 1'b0; md_busy = 1'b0; hold = 1'b0; flush = 1'b0;

        cyc(0, 0,0,0, 0,0,0, 0,0, 5'b10000, 0,0,0,3'b000, "reset");
        // Load-use
        cyc(1, 0,0,0, 0,0,0, 8,TNEW_DM, 5'b00000, 0,0,0,3'b000, "lw8");
        cyc(1, 8,1,1, 0,0,0, 10,TNEW_ALU, 5'b00000, 1,0,0,3'b001, "loaduse_stall");
        cyc(1, 8,1,1, 0,0,0, 10,TNEW_ALU, 5'b00000, 0,0,0,3'b010, "loaduse_go");
        cyc(0, 0,0,0, 0,0,0, 0,0, 5'b00001, 0,0,0,3'b101, "flush_a");
        // Branch after ALU, then saturated tnew forwarded from the oldest slot
        cyc(1, 0,0,0, 0,0,0, 9,TNEW_ALU, 5'b00000, 0,0,0,3'b000, "addu9");
        cyc(1, 9,1,0, 0,1,0, 0,TNEW_PC, 5'b00000, 1,0,0,3'b001, "branch_stall");
        cyc(1, 9,1,0, 0,1,0, 0,TNEW_PC, 5'b00000, 0,2,0,3'b010, "branch_fwd");
        cyc(1, 9,1,1, 9,1,1, 0,TNEW_PC, 5'b00000, 0,3,3,3'b101, "rs_eq_rt");
        cyc(0, 0,0,0, 0,0,0, 0,0, 5'b00001, 0,0,0,3'b011, "flush_b");
        // Shadowing
        cyc(1, 0,0,0, 0,0,0, 5,TNEW_ALU, 5'b00000, 0,0,0,3'b000, "ori5");
        cyc(1, 0,0,0, 0,0,0, 5,TNEW_DM, 5'b00000, 0,0,0,3'b001, "lw5");
        cyc(1, 0,0,0, 5,1,1, 11,TNEW_ALU, 5'b00000, 1,0,0,3'b011, "shadow_stall");
        cyc(1, 0,0,0, 5,1,1, 11,TNEW_ALU, 5'b00000, 0,0,0,3'b110, "shadow_go");
        cyc(0, 0,0,0, 0,0,0, 0,0, 5'b00001, 0,0,0,3'b101, "flush_c");
        // Zero register
        cyc(1, 0,0,0, 0,0,0, 0,TNEW_DM, 5'b00000, 0,0,0,3'b000, "lw_r0");
        cyc(1, 0,1,1, 0,0,0, 12,TNEW_ALU, 5'b00000, 0,0,0,3'b001, "zero_reg");
        cyc(0, 0,0,0, 0,0,0, 0,0, 5'b00001, 0,0,0,3'b011, "flush_d");
        // Hold and flush
        cyc(1, 0,0,0, 0,0,0, 1,TNEW_DM, 5'b00000, 0,0,0,3'b000, "fill1");
        cyc(1, 0,0,0, 0,0,0, 2,TNEW_DM, 5'b00000, 0,0,0,3'b001, "fill2");
        cyc(1, 0,0,0, 0,0,0, 3,TNEW_DM, 5'b00000, 0,0,0,3'b011, "fill3");
        cyc(1, 1,1,0, 2,1,1, 0,TNEW_PC, 5'b00010, 0,3,0,3'b111, "hold1");
        cyc(1, 1,1,0, 2,1,1, 0,TNEW_PC, 5'b00010, 0,3,0,3'b111, "hold2");
        cyc(1, 1,1,0, 2,1,1, 0,TNEW_PC, 5'b00011, 0,3,0,3'b111, "hold_flush");
        cyc(1, 0,0,0, 0,0,0, 14,TNEW_ALU, 5'b00000, 0,0,0,3'b000, "after_flush");
        // Mult/div busy, then reset during a stall
        cyc(1, 0,0,0, 0,0,0, 13,TNEW_ALU, 5'b01100, 1,0,0,3'b001, "md1");
        cyc(1, 0,0,0, 0,0,0, 13,TNEW_ALU, 5'b01100, 1,0,0,3'b010, "md2");
        cyc(1, 0,0,0, 0,0,0, 13,TNEW_ALU, 5'b00000, 0,0,0,3'b100, "md_done");
        cyc(1, 13,1,0, 0,0,0, 0,TNEW_PC, 5'b00000, 1,0,0,3'b001, "reg_stall");
        cyc(1, 13,1,0, 0,0,0, 0,TNEW_PC, 5'b10000, 0,0,0,3'b000, "reset_mid_stall");
        cyc(1, 0,0,0, 0,0,0, 0,TNEW_PC, 5'b11100, 1,0,0,3'b000, "reset_md");
        cyc(0, 0,0,0, 0,0,0, 0,TUSE_NONE, 5'b00000, 0,0,0,3'b000, "post_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
